// File: rtl/pdp8_io_pkg.sv
// Shared PDP-8 IO bus definitions: word type, CPU major states, KL8E IOT function codes.
package pdp8_io_pkg;

  typedef logic [11:0] word_t;

  typedef enum logic [3:0] {
    F0 = 4'd0, F1 = 4'd1, F2 = 4'd2,  F3 = 4'd3,
    D0 = 4'd4, D1 = 4'd5, D2 = 4'd6,  D3 = 4'd7,
    E0 = 4'd8, E1 = 4'd9, E2 = 4'd10, E3 = 4'd11
  } cpu_state_e;

  // Keyboard (even device code) functions
  localparam logic [2:0] KCF = 3'd0;
  localparam logic [2:0] KSF = 3'd1;
  localparam logic [2:0] KCC = 3'd2;
  localparam logic [2:0] KRS = 3'd4;
  localparam logic [2:0] KIE = 3'd5;
  localparam logic [2:0] KRB = 3'd6;

  // Printer (odd device code) functions
  localparam logic [2:0] TFL = 3'd0;
  localparam logic [2:0] TSF = 3'd1;
  localparam logic [2:0] TCF = 3'd2;
  localparam logic [2:0] TPC = 3'd4;
  localparam logic [2:0] TSK = 3'd5;
  localparam logic [2:0] TLS = 3'd6;

endpackage

// File: rtl/pdp8_kl8_chan.sv
// One KL8E channel: rx buffer, KF/PF/IE flags, tx holding register; IOT response is combinational.
// KL8_RX_FIFO_EN selects an RX_DEPTH-deep receive FIFO; otherwise a single-byte buffer.
module pdp8_kl8_chan
  import pdp8_io_pkg::*;
#(
  parameter int RX_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kbd_sel_i,
  input  logic       prt_sel_i,
  input  logic       f1_i,
  input  logic [2:0] fn_i,
  input  logic [7:0] ac_i,
  output logic       skip_o,
  output logic       clear_ac_o,
  output logic       data_avail_o,
  output word_t      data_o,
  output logic       irq_o,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic       rx_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i
);

`ifdef KL8_RX_FIFO_EN
  localparam int DEPTH = RX_DEPTH;
`else
  localparam int DEPTH = 1;
  localparam int unused_rx_depth = RX_DEPTH;
`endif
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    mem_q [2**AW];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          supp_q, supp_d, ie_q, ie_d, pf_q, pf_d;
  logic          tx_vld_q, tx_vld_d, rx_rdy_q, rx_rdy_d;
  logic [7:0]    tx_dat_q, tx_dat_d;

  logic       kbd_go, prt_go, empty, kf, push, pop, load, tx_done;
  logic [7:0] head;

  assign kbd_go  = kbd_sel_i & f1_i;
  assign prt_go  = prt_sel_i & f1_i;
  assign empty   = (cnt_q == '0);
  assign head    = empty ? 8'h00 : mem_q[rd_q];
  assign kf      = !empty & !supp_q;
  assign push    = rx_valid_i & rx_rdy_q;
  assign pop     = kbd_go & (fn_i == KRB) & !empty;
  assign load    = prt_go & ((fn_i == TPC) | (fn_i == TLS));
  assign tx_done = tx_vld_q & tx_ready_i;

  always_comb begin
    wr_d     = wr_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    supp_d   = supp_q;
    ie_d     = ie_q;
    pf_d     = pf_q;
    tx_vld_d = tx_vld_q;
    tx_dat_d = tx_dat_q;
    if (push) wr_d = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (pop)  rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    if (pop && !push) cnt_d = cnt_q - 1'b1;
    // A fresh byte always re-arms a flag that KCF/KCC suppressed
    if (push) supp_d = 1'b0;
    else if (kbd_go && (fn_i == KCF || fn_i == KCC)) supp_d = 1'b1;
    if (kbd_go && fn_i == KIE) ie_d = ac_i[0];
    if (tx_done) begin
      tx_vld_d = 1'b0;
      pf_d     = 1'b1;
    end
    if (prt_go && fn_i == TFL) pf_d = 1'b1;
    if (prt_go && (fn_i == TCF || fn_i == TLS)) pf_d = 1'b0;
    if (load) begin
      tx_vld_d = 1'b1;
      tx_dat_d = ac_i;
    end
    rx_rdy_d = (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      supp_q   <= 1'b0;
      ie_q     <= 1'b1;
      pf_q     <= 1'b0;
      tx_vld_q <= 1'b0;
      tx_dat_q <= 8'h00;
      rx_rdy_q <= 1'b1;
    end else begin
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      supp_q   <= supp_d;
      ie_q     <= ie_d;
      pf_q     <= pf_d;
      tx_vld_q <= tx_vld_d;
      tx_dat_q <= tx_dat_d;
      rx_rdy_q <= rx_rdy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= rx_data_i;
  end

  always_comb begin
    skip_o       = 1'b0;
    clear_ac_o   = 1'b0;
    data_avail_o = 1'b0;
    data_o       = '0;
    if (kbd_sel_i) begin
      case (fn_i)
        KSF: skip_o = kf;
        KCC: clear_ac_o = 1'b1;
        KRS: begin
          data_avail_o = 1'b1;
          data_o       = {4'b0, head};
        end
        KRB: begin
          clear_ac_o   = 1'b1;
          data_avail_o = 1'b1;
          data_o       = {4'b0, head};
        end
        default: ;
      endcase
    end
    if (prt_sel_i) begin
      case (fn_i)
        TSF:     skip_o = pf_q;
        TSK:     skip_o = pf_q | kf;
        default: ;
      endcase
    end
  end

  assign irq_o      = ie_q & (kf | pf_q);
  assign rx_ready_o = rx_rdy_q;
  assign tx_valid_o = tx_vld_q;
  assign tx_data_o  = tx_dat_q;

endmodule

// File: rtl/pdp8_kl8_mux.sv
// NCHAN KL8E keyboard/printer pairs behind one IOT decoder with a shared interrupt request.
// Build option KL8_RX_FIFO_EN enables RX_DEPTH-deep receive FIFOs (default: single-byte buffers).
module pdp8_kl8_mux
  import pdp8_io_pkg::*;
#(
  parameter int          NCHAN    = 4,
  parameter int          RX_DEPTH = 8,
  parameter logic [5:0]  DEV_BASE = 6'o40
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iot,
  input  logic [3:0]           state,
  input  logic [11:0]          mb,
  input  logic [5:0]           io_select,
  input  logic [11:0]          io_data_in,
  output logic [11:0]          io_data_out,
  output logic                 io_data_avail,
  output logic                 io_interrupt,
  output logic                 io_skip,
  output logic                 io_clear_ac,
  input  logic [8*NCHAN-1:0]   rx_data,
  input  logic [NCHAN-1:0]     rx_valid,
  output logic [NCHAN-1:0]     rx_ready,
  output logic [8*NCHAN-1:0]   tx_data,
  output logic [NCHAN-1:0]     tx_valid,
  input  logic [NCHAN-1:0]     tx_ready
);

  logic [NCHAN-1:0] kbd_sel, prt_sel, ch_skip, ch_clr, ch_avail, ch_irq;
  word_t            ch_dout [NCHAN];
  logic             f1;
  logic             unused_bus_bits;

  assign f1              = (state == F1);
  assign unused_bus_bits = ^{mb[11:3], io_data_in[11:8]};

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    localparam logic [5:0] KCODE = DEV_BASE + 6'(2 * i);

    assign kbd_sel[i] = iot && (io_select == KCODE);
    assign prt_sel[i] = iot && (io_select == KCODE + 6'd1);

    pdp8_kl8_chan #(.RX_DEPTH(RX_DEPTH)) u_chan (
      .clk          (clk),
      .reset        (reset),
      .kbd_sel_i    (kbd_sel[i]),
      .prt_sel_i    (prt_sel[i]),
      .f1_i         (f1),
      .fn_i         (mb[2:0]),
      .ac_i         (io_data_in[7:0]),
      .skip_o       (ch_skip[i]),
      .clear_ac_o   (ch_clr[i]),
      .data_avail_o (ch_avail[i]),
      .data_o       (ch_dout[i]),
      .irq_o        (ch_irq[i]),
      .rx_data_i    (rx_data[8*i +: 8]),
      .rx_valid_i   (rx_valid[i]),
      .rx_ready_o   (rx_ready[i]),
      .tx_data_o    (tx_data[8*i +: 8]),
      .tx_valid_o   (tx_valid[i]),
      .tx_ready_i   (tx_ready[i])
    );
  end

  // At most one channel is selected, so a plain OR acts as the output mux
  always_comb begin
    io_data_out = '0;
    for (int i = 0; i < NCHAN; i++) io_data_out |= ch_dout[i];
  end

  assign io_skip       = |ch_skip;
  assign io_clear_ac   = |ch_clr;
  assign io_data_avail = |ch_avail;
  assign io_interrupt  = |ch_irq;

endmodule
